voice_allocator: RTL and testbench

//  Polyphonic voice scheduler between the UART receiver and the tone generators.

---
 rtl/voice_allocator.sv | 152 +++++++++++++++
 tb/tb_voice_allocator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns accepted UART key bytes to tone channels,
// holds each for a fixed number of cycles, retriggers repeats and steals the
// oldest channel when all are busy.
module voice_allocator #(
  parameter int unsigned C_CLK_FRQ = 100_000_000,
  parameter int unsigned C_NOTE_MS = 500,
  parameter int unsigned C_VOICES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  UART_valid,
  input  logic                  UART_err,
  input  logic [7:0]            UART_msg,
  output logic [8*C_VOICES-1:0] voice_note,
  output logic [C_VOICES-1:0]   voice_active,
  output logic [C_VOICES-1:0]   voice_trig,
  output logic                  steal,
  output logic                  drop
);

  // 64-bit product: the default clock and duration overflow 32 bits.
  localparam longint unsigned PeriodL  = (64'(C_CLK_FRQ) * 64'(C_NOTE_MS)) / 64'd1000;
  localparam int unsigned     C_PERIOD = 32'(PeriodL);
  localparam int unsigned     TW       = $clog2(C_PERIOD + 1);
  localparam int unsigned     IW       = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
  localparam logic [TW-1:0]   LastTick = TW'(C_PERIOD - 1);

  typedef enum logic {StFree, StHold} ch_state_e;

  ch_state_e             state_q [C_VOICES];
  ch_state_e             state_d [C_VOICES];
  logic [TW-1:0]         timer_q [C_VOICES];
  logic [TW-1:0]         timer_d [C_VOICES];
  logic [7:0]            note_q  [C_VOICES];
  logic [7:0]            note_d  [C_VOICES];
  logic [C_VOICES-1:0]   trig_q, trig_d;
  logic                  steal_q, steal_d;
  logic                  drop_q, drop_d;

  logic                  accept;
  logic [C_VOICES-1:0]   expiring;
  logic                  hit, free_found;
  logic [IW-1:0]         hit_idx, free_idx, old_idx, sel_idx;
  logic [TW-1:0]         old_timer;

  // Channel selection (retrigger > free > steal) and per-channel next state
  always_comb begin
    accept     = UART_valid && !UART_err && (UART_msg != 8'h00);
    drop_d     = UART_valid && (UART_err || (UART_msg == 8'h00));
    expiring   = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_timer  = timer_q[0];
    trig_d     = '0;
    steal_d    = 1'b0;

    for (int i = 0; i < C_VOICES; i++) begin
      expiring[i] = (state_q[i] == StHold) && (timer_q[i] == LastTick);
    end
    for (int i = 0; i < C_VOICES; i++) begin
      if (!hit && (state_q[i] == StHold) && (note_q[i] == UART_msg)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    // An expiring channel is as good as free this cycle.
    for (int i = 0; i < C_VOICES; i++) begin
      if (!free_found && ((state_q[i] == StFree) || expiring[i])) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < C_VOICES; i++) begin
      if (timer_q[i] > old_timer) begin
        old_idx   = IW'(i);
        old_timer = timer_q[i];
      end
    end

    if (hit) begin
      sel_idx = hit_idx;
    end else if (free_found) begin
      sel_idx = free_idx;
    end else begin
      sel_idx = old_idx;
      steal_d = accept;
    end

    for (int i = 0; i < C_VOICES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      note_d[i]  = note_q[i];
      if (state_q[i] == StHold) begin
        if (expiring[i]) begin
          state_d[i] = StFree;
          timer_d[i] = '0;
          note_d[i]  = 8'h00;
        end else begin
          timer_d[i] = timer_q[i] + TW'(1);
        end
      end
      if (accept && (sel_idx == IW'(i))) begin
        state_d[i] = StHold;
        timer_d[i] = '0;
        note_d[i]  = UART_msg;
        trig_d[i]  = 1'b1;
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_VOICES; i++) begin
        state_q[i] <= StFree;
        timer_q[i] <= '0;
        note_q[i]  <= 8'h00;
      end
      trig_q  <= '0;
      steal_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < C_VOICES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        note_q[i]  <= note_d[i];
      end
      trig_q  <= trig_d;
      steal_q <= steal_d;
      drop_q  <= drop_d;
    end
  end

  // Flatten channel registers onto the output buses
  always_comb begin
    voice_note   = '0;
    voice_active = '0;
    for (int i = 0; i < C_VOICES; i++) begin
      voice_note[8*i +: 8] = note_q[i];
      voice_active[i]      = (state_q[i] == StHold);
    end
  end

  assign voice_trig = trig_q;
  assign steal      = steal_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised and directed bench for voice_allocator with a countdown-based
// reference model feeding a scoreboard queue.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          UART_valid, UART_err;
  logic [7:0]    UART_msg;
  logic [8*NV-1:0] voice_note;
  logic [NV-1:0] voice_active, voice_trig;
  logic          steal, drop;

  voice_allocator #(
    .C_CLK_FRQ(1000),
    .C_NOTE_MS(10),
    .C_VOICES (NV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .UART_valid  (UART_valid),
    .UART_err    (UART_err),
    .UART_msg    (UART_msg),
    .voice_note  (voice_note),
    .voice_active(voice_active),
    .voice_trig  (voice_trig),
    .steal       (steal),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*NV-1:0] note;
    logic [NV-1:0]   act;
    logic [NV-1:0]   trig;
    logic            stl;
    logic            drp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: rem[i] = cycles channel i will still sound, including the current one.
  int         rem   [NV];
  logic [7:0] mnote [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      rem[i]   = 0;
      mnote[i] = 8'h00;
    end
  endtask

  task automatic model_step(input logic v, input logic e, input logic [7:0] m);
    exp_t x;
    int   sel = -1;
    bit   stl = 0;
    bit   acc = v && !e && (m != 8'h00);
    if (acc) begin
      for (int i = 0; i < NV; i++) if (sel < 0 && rem[i] > 0 && mnote[i] == m) sel = i;
      for (int i = 0; i < NV; i++) if (sel < 0 && rem[i] <= 1) sel = i;
      if (sel < 0) begin
        sel = 0;
        for (int i = 1; i < NV; i++) if (rem[i] < rem[sel]) sel = i;
        stl = 1;
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (rem[i] > 0) rem[i]--;
      if (rem[i] == 0) mnote[i] = 8'h00;
    end
    x.trig = '0;
    if (acc) begin
      rem[sel]    = P;
      mnote[sel]  = m;
      x.trig[sel] = 1'b1;
    end
    for (int i = 0; i < NV; i++) begin
      x.note[8*i +: 8] = mnote[i];
      x.act[i]         = (rem[i] > 0);
    end
    x.stl = stl;
    x.drp = v && (e || m == 8'h00);
    exp_q.push_back(x);
  endtask

  // Monitor: one expectation per clocked cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("sb_note",  64'(voice_note),   64'(x.note));
      chk("sb_active", 64'(voice_active), 64'(x.act));
      chk("sb_trig",  64'(voice_trig),   64'(x.trig));
      chk("sb_steal", 64'(steal),        64'(x.stl));
      chk("sb_drop",  64'(drop),         64'(x.drp));
      chk("trig_at_most_one", 64'($countones(voice_trig) <= 1), 64'(1));
      if (steal) chk("steal_one_trig", 64'($countones(voice_trig)), 64'(1));
    end
  end

  // Drive one cycle; returns at the following negedge
  task automatic cycle(input logic v, input logic e, input logic [7:0] m);
    UART_valid = v;
    UART_err   = e;
    UART_msg   = m;
    @(posedge clk);
    model_step(v, e, m);
    @(negedge clk);
    UART_valid = 1'b0;
    UART_err   = 1'b0;
    UART_msg   = 8'h00;
  endtask

  task automatic key(input logic [7:0] m);
    cycle(1'b1, 1'b0, m);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_note"},   64'(voice_note),   64'(0));
    chk({tag, "_active"}, 64'(voice_active), 64'(0));
    chk({tag, "_trig"},   64'(voice_trig),   64'(0));
    chk({tag, "_steal"},  64'(steal),        64'(0));
    chk({tag, "_drop"},   64'(drop),         64'(0));
  endtask

  // Assert reset between clock edges and check outputs clear before the next edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("arst");
    exp_q.delete();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [8*NV-1:0] snap_note;
    logic [NV-1:0]   snap_act;

    rst        = 1'b1;
    UART_valid = 1'b0;
    UART_err   = 1'b0;
    UART_msg   = 8'h00;
    model_clear();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single note lasts exactly P cycles
    key(8'h3C);
    chk("single_note", 64'(voice_note[7:0]), 64'h3C);
    chk("single_active", 64'(voice_active), 64'b0001);
    chk("single_trig", 64'(voice_trig), 64'b0001);
    cnt = 1;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      if (voice_active[0]) cnt++;
    end
    chk("single_len", 64'(cnt), 64'(P));
    chk("single_end_note", 64'(voice_note), 64'(0));

    // Fill all channels, then steal the oldest
    key(8'h41); key(8'h42); key(8'h43); key(8'h44);
    chk("fill_active", 64'(voice_active), 64'hF);
    chk("fill_notes", 64'(voice_note), 64'h44434241);
    idle(1);
    key(8'h45);
    chk("steal_trig", 64'(voice_trig), 64'b0001);
    chk("steal_flag", 64'(steal), 64'(1));
    chk("steal_note", 64'(voice_note), 64'h44434245);
    idle(12);

    // Retrigger extends channel 0 to 15 cycles, no other channel used
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0 || k == 5) key(8'h3C); else idle(1);
      if (k == 5) begin
        chk("retrig_trig", 64'(voice_trig), 64'b0001);
        chk("retrig_steal", 64'(steal), 64'(0));
      end
      if (voice_active[0]) cnt++;
      chk("retrig_others", 64'(voice_active[NV-1:1]), 64'(0));
    end
    chk("retrig_len", 64'(cnt), 64'(15));

    // Errors and silence are dropped without touching channels
    key(8'h3C);
    snap_note = voice_note;
    snap_act  = voice_active;
    cycle(1'b1, 1'b1, 8'h50);
    chk("err_drop", 64'(drop), 64'(1));
    chk("err_note", 64'(voice_note), 64'(snap_note));
    chk("err_active", 64'(voice_active), 64'(snap_act));
    cycle(1'b1, 1'b0, 8'h00);
    chk("zero_drop", 64'(drop), 64'(1));
    chk("zero_active", 64'(voice_active), 64'(snap_act));
    idle(1);
    chk("drop_clear", 64'(drop), 64'(0));
    idle(12);

    // Expiry collision: channel 0 re-taken with no gap
    key(8'h3C);
    cnt = 0;
    for (int k = 1; k < 10; k++) begin
      idle(1);
      if (voice_active[0]) cnt++;
    end
    key(8'h40);
    chk("coll_hold", 64'(cnt), 64'(9));
    chk("coll_active", 64'(voice_active[0]), 64'(1));
    chk("coll_note", 64'(voice_note[7:0]), 64'h40);
    chk("coll_trig", 64'(voice_trig), 64'b0001);
    chk("coll_steal", 64'(steal), 64'(0));
    idle(12);

    // Async reset with three active channels
    key(8'h11); key(8'h12); key(8'h13);
    chk("pre_arst_active", 64'(voice_active), 64'b0111);
    async_reset();
    key(8'h30);
    chk("post_arst_note", 64'(voice_note[7:0]), 64'h30);
    chk("post_arst_active", 64'(voice_active), 64'b0001);
    idle(12);

    // Random traffic against the model; small key alphabet forces retriggers
    for (int k = 0; k < 2000; k++) begin
      logic v, e;
      logic [7:0] m;
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 9) == 0);
      m = 8'($urandom_range(0, 6));
      cycle(v, e, m);
    end

    #1;
    chk("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
